// File: rtl/br_j_pkg.sv
// Shared op codes, pc_sel codes, FSM encoding and helpers for the
// branch/jump resolution unit.
package br_j_pkg;

    // Resolve-side op codes
    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_J    = 3'b001;
    localparam logic [2:0] OP_BALZ = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_BNE  = 3'b100;
    localparam logic [2:0] OP_BGEZ = 3'b101;
    localparam logic [2:0] OP_BLTZ = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // Next-PC mux select codes
    localparam logic [1:0] SEL_SEQ   = 2'b00;
    localparam logic [1:0] SEL_JMP   = 2'b01;
    localparam logic [1:0] SEL_BALZ  = 2'b10;
    localparam logic [1:0] SEL_PCREL = 2'b11;

    // Flush FSM encoding
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // 2-bit saturating counter limits
    localparam logic [1:0] CNT_MAX = 2'b11;
    localparam logic [1:0] CNT_MIN = 2'b00;

    // Decoded view of one resolve request
    typedef struct packed {
        logic       taken;    // actual direction (J counts as taken)
        logic [1:0] sel;      // pc_sel to drive
        logic       is_cond;  // conditional op: trains the BHT
        logic       is_balz;  // writes the link register when taken
    } decode_t;

    // Saturating increment/decrement of a 2-bit predictor counter
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_MAX) nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_MIN) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

    // Op + ALU status {zero, neg} -> direction, select and side effects
    function automatic decode_t decode_op(input logic [2:0] op, input logic [1:0] status);
        decode_t d;
        logic    zero;
        logic    neg;
        zero = status[1];
        neg  = status[0];
        d.taken   = 1'b0;
        d.sel     = SEL_SEQ;
        d.is_cond = 1'b0;
        d.is_balz = 1'b0;
        case (op)
            OP_J: begin
                d.taken = 1'b1;
                d.sel   = SEL_JMP;
            end
            OP_BALZ: begin
                d.taken   = zero;
                d.is_cond = 1'b1;
                d.is_balz = 1'b1;
                d.sel     = zero ? SEL_BALZ : SEL_SEQ;
            end
            OP_BEQ, OP_BNE, OP_BGEZ, OP_BLTZ: begin
                d.is_cond = 1'b1;
                case (op)
                    OP_BEQ:  d.taken = zero;
                    OP_BNE:  d.taken = ~zero;
                    OP_BGEZ: d.taken = ~neg;
                    default: d.taken = neg;
                endcase
                d.sel = d.taken ? SEL_PCREL : SEL_SEQ;
            end
            default: begin
                // NONE and the reserved code: never taken, sequential
                d.taken = 1'b0;
                d.sel   = SEL_SEQ;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: DEPTH x 2-bit saturating counters with one
// combinational prediction read port and one training write port.
module br_bht
    import br_j_pkg::*;
#(
    parameter int         DEPTH = 16,
    parameter int         IDX_W = $clog2(DEPTH),
    parameter logic [1:0] INIT  = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    // Only the direction bit of each counter is needed on the read side
    logic taken_arr [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [1:0] cnt_reg;

            // Per-entry counter; training writes are seen by reads next cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= INIT;
                end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                    cnt_reg <= sat_update(cnt_reg, upd_taken);
                end
            end

            assign taken_arr[gi] = cnt_reg[1];
        end
    endgenerate

    assign rd_taken = taken_arr[rd_idx];

endmodule

// File: rtl/br_j_resolve_unit.sv
// Branch/jump resolution unit: resolves one op per accept into a
// registered pc_sel, trains the BHT, flags mispredicts and holds a
// flush window before accepting the next op.
module br_j_resolve_unit
    import br_j_pkg::*;
#(
    parameter int         BHT_DEPTH    = 16,
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [1:0] BHT_INIT     = 2'b01,
    localparam int        IDX_W        = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_taken,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [2:0]       res_op,
    input  logic [1:0]       res_status,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             res_pred_taken,
    output logic [1:0]       pc_sel,
    output logic             sel_valid,
    output logic             mispredict,
    output logic             flush,
    output logic             link_we
);

    localparam logic       HAS_FLUSH = (FLUSH_CYCLES > 0);
    localparam logic [3:0] FLUSH_LD  = 4'(FLUSH_CYCLES);

    logic [0:0] state_reg;
    logic [3:0] fcnt_reg;
    logic [1:0] pc_sel_reg;
    logic       sel_valid_reg;
    logic       mispredict_reg;
    logic       link_we_reg;

    decode_t dec;
    logic    accept;
    logic    mis;

    assign dec       = decode_op(res_op, res_status);
    assign res_ready = (state_reg == ST_RUN);
    assign accept    = res_valid & res_ready;
    assign mis       = (dec.taken != res_pred_taken);

    // Predictor storage; only conditional ops train it
    br_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W),
        .INIT  (BHT_INIT)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pred_idx),
        .rd_taken  (pred_taken),
        .upd_en    (accept & dec.is_cond),
        .upd_idx   (res_idx),
        .upd_taken (dec.taken)
    );

    // Result registers: pulses for one cycle per accept, pc_sel holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_sel_reg     <= SEL_SEQ;
            sel_valid_reg  <= 1'b0;
            mispredict_reg <= 1'b0;
            link_we_reg    <= 1'b0;
        end else begin
            sel_valid_reg  <= accept;
            mispredict_reg <= accept & mis;
            link_we_reg    <= accept & dec.is_balz & dec.taken;
            if (accept) begin
                pc_sel_reg <= dec.sel;
            end
        end
    end

    // Flush FSM: a mispredict opens a FLUSH_CYCLES-long window with res_ready low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            fcnt_reg  <= 4'd0;
        end else if (state_reg == ST_RUN) begin
            if (accept && mis && HAS_FLUSH) begin
                state_reg <= ST_FLUSH;
                fcnt_reg  <= FLUSH_LD;
            end
        end else begin
            fcnt_reg <= fcnt_reg - 4'd1;
            if (fcnt_reg == 4'd1) begin
                state_reg <= ST_RUN;
            end
        end
    end

    assign pc_sel     = pc_sel_reg;
    assign sel_valid  = sel_valid_reg;
    assign mispredict = mispredict_reg;
    assign link_we    = link_we_reg;
    assign flush      = (state_reg == ST_FLUSH);

endmodule

// File: tb/tb_br_j_resolve_unit.sv
// Directed bench for br_j_resolve_unit (BHT_DEPTH=16, FLUSH_CYCLES=2).
module tb_br_j_resolve_unit;

    logic       clk;
    logic       rst_n;
    logic [3:0] pred_idx;
    logic       pred_taken;
    logic       res_valid;
    logic       res_ready;
    logic [2:0] res_op;
    logic [1:0] res_status;
    logic [3:0] res_idx;
    logic       res_pred_taken;
    logic [1:0] pc_sel;
    logic       sel_valid;
    logic       mispredict;
    logic       flush;
    logic       link_we;

    int n_cmp;
    int n_err;

    br_j_resolve_unit #(
        .BHT_DEPTH    (16),
        .FLUSH_CYCLES (2),
        .BHT_INIT     (2'b01)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_idx       (pred_idx),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_op         (res_op),
        .res_status     (res_status),
        .res_idx        (res_idx),
        .res_pred_taken (res_pred_taken),
        .pc_sel         (pc_sel),
        .sel_valid      (sel_valid),
        .mispredict     (mispredict),
        .flush          (flush),
        .link_we        (link_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one op at the negedge, let it be accepted at the next posedge,
    // then leave the bench 1 time unit after that edge with res_valid low.
    task automatic issue(input logic [2:0] op, input logic [1:0] st,
                         input logic [3:0] idx, input logic pred);
        @(negedge clk);
        res_op         = op;
        res_status     = st;
        res_idx        = idx;
        res_pred_taken = pred;
        res_valid      = 1'b1;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        $display("txn op=%b st=%b idx=%0d pred=%b -> pc_sel=%b sv=%b mis=%b flush=%b lwe=%b",
                 op, st, idx, pred, pc_sel, sel_valid, mispredict, flush, link_we);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pc_sel !== 2'b00) begin n_err++; $display("FAIL rst_pc_sel: got %b want 00", pc_sel); end
        n_cmp++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL rst_sel_valid: got %b want 0", sel_valid); end
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL rst_mispredict: got %b want 0", mispredict); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL rst_link_we: got %b want 0", link_we); end
        for (int i = 0; i < 16; i++) begin
            pred_idx = 4'(i);
            #1;
            n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_bht[%0d]: got %b want 0", i, pred_taken); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL rst_res_ready: got %b want 1", res_ready); end
        $display("txn reset released: res_ready=%b", res_ready);
    endtask

    task automatic test_beq_mispredict;
        issue(3'b011, 2'b10, 4'd3, 1'b0);
        n_cmp++; if (pc_sel !== 2'b11) begin n_err++; $display("FAIL beq_pc_sel: got %b want 11", pc_sel); end
        n_cmp++; if (sel_valid !== 1'b1) begin n_err++; $display("FAIL beq_sel_valid: got %b want 1", sel_valid); end
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL beq_mispredict: got %b want 1", mispredict); end
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL beq_flush_c0: got %b want 1", flush); end
        n_cmp++; if (res_ready !== 1'b0) begin n_err++; $display("FAIL beq_ready_c0: got %b want 0", res_ready); end
        pred_idx = 4'd3;
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL beq_bht3: got %b want 1", pred_taken); end
        @(posedge clk);
        #1;
        n_cmp++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL beq_sel_valid_c1: got %b want 0", sel_valid); end
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL beq_mispredict_c1: got %b want 0", mispredict); end
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL beq_flush_c1: got %b want 1", flush); end
        n_cmp++; if (res_ready !== 1'b0) begin n_err++; $display("FAIL beq_ready_c1: got %b want 0", res_ready); end
        n_cmp++; if (pc_sel !== 2'b11) begin n_err++; $display("FAIL beq_pc_sel_hold: got %b want 11", pc_sel); end
        @(posedge clk);
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL beq_flush_c2: got %b want 0", flush); end
        n_cmp++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL beq_ready_c2: got %b want 1", res_ready); end
    endtask

    task automatic test_reset_mid_flush;
        issue(3'b100, 2'b00, 4'd7, 1'b0);
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL rmf_flush_before: got %b want 1", flush); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rmf_flush_async: got %b want 0", flush); end
        n_cmp++; if (pc_sel !== 2'b00) begin n_err++; $display("FAIL rmf_pc_sel: got %b want 00", pc_sel); end
        n_cmp++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL rmf_sel_valid: got %b want 0", sel_valid); end
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL rmf_mispredict: got %b want 0", mispredict); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL rmf_res_ready: got %b want 1", res_ready); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rmf_flush_after: got %b want 0", flush); end
        pred_idx = 4'd3;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rmf_bht3: got %b want 0", pred_taken); end
        pred_idx = 4'd7;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rmf_bht7: got %b want 0", pred_taken); end
        $display("txn reset mid-flush done: res_ready=%b flush=%b", res_ready, flush);
    endtask

    task automatic test_bne_not_taken;
        for (int i = 0; i < 3; i++) begin
            issue(3'b100, 2'b10, 4'd9, 1'b0);
            n_cmp++; if (pc_sel !== 2'b00) begin n_err++; $display("FAIL bne_nt_pc_sel[%0d]: got %b want 00", i, pc_sel); end
            n_cmp++; if (sel_valid !== 1'b1) begin n_err++; $display("FAIL bne_nt_sel_valid[%0d]: got %b want 1", i, sel_valid); end
            n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL bne_nt_mispredict[%0d]: got %b want 0", i, mispredict); end
            n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL bne_nt_flush[%0d]: got %b want 0", i, flush); end
        end
        // Counter must sit at 00: one taken update gives 01, a second gives 10
        issue(3'b100, 2'b00, 4'd9, 1'b1);
        n_cmp++; if (pc_sel !== 2'b11) begin n_err++; $display("FAIL bne_t_pc_sel: got %b want 11", pc_sel); end
        pred_idx = 4'd9;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL bne_sat0_step1: got %b want 0", pred_taken); end
        issue(3'b100, 2'b00, 4'd9, 1'b1);
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL bne_sat0_step2: got %b want 1", pred_taken); end
    endtask

    task automatic test_bgez_saturate;
        pred_idx = 4'd5;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL bgez_initial: got %b want 0", pred_taken); end
        issue(3'b101, 2'b00, 4'd5, 1'b1);
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL bgez_after1: got %b want 1", pred_taken); end
        n_cmp++; if (pc_sel !== 2'b11) begin n_err++; $display("FAIL bgez_pc_sel: got %b want 11", pc_sel); end
        // Second update with the lookup on the same index in the same cycle
        @(negedge clk);
        res_op = 3'b101; res_status = 2'b00; res_idx = 4'd5; res_pred_taken = 1'b1; res_valid = 1'b1;
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL bgez_same_cycle_old: got %b want 1", pred_taken); end
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL bgez_same_cycle_new: got %b want 1", pred_taken); end
        $display("txn op=101 st=00 idx=5 pred=1 (same-cycle lookup) -> pred_taken=%b", pred_taken);
        issue(3'b101, 2'b00, 4'd5, 1'b1);
        issue(3'b101, 2'b00, 4'd5, 1'b1);
        // Saturated at 11: one not-taken leaves 10 (taken), the next 01
        issue(3'b101, 2'b01, 4'd5, 1'b0);
        n_cmp++; if (pc_sel !== 2'b00) begin n_err++; $display("FAIL bgez_nt_pc_sel: got %b want 00", pc_sel); end
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL bgez_sat3_step1: got %b want 1", pred_taken); end
        issue(3'b101, 2'b01, 4'd5, 1'b0);
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL bgez_sat3_step2: got %b want 0", pred_taken); end
    endtask

    task automatic test_j_balz;
        issue(3'b001, 2'b00, 4'd11, 1'b0);
        n_cmp++; if (pc_sel !== 2'b01) begin n_err++; $display("FAIL j_pc_sel: got %b want 01", pc_sel); end
        n_cmp++; if (mispredict !== 1'b1) begin n_err++; $display("FAIL j_mispredict: got %b want 1", mispredict); end
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL j_flush: got %b want 1", flush); end
        n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL j_link_we: got %b want 0", link_we); end
        pred_idx = 4'd11;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL j_no_bht_write: got %b want 0", pred_taken); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL j_ready_after: got %b want 1", res_ready); end
        issue(3'b010, 2'b10, 4'd12, 1'b1);
        n_cmp++; if (pc_sel !== 2'b10) begin n_err++; $display("FAIL balz_pc_sel: got %b want 10", pc_sel); end
        n_cmp++; if (link_we !== 1'b1) begin n_err++; $display("FAIL balz_link_we: got %b want 1", link_we); end
        n_cmp++; if (mispredict !== 1'b0) begin n_err++; $display("FAIL balz_mispredict: got %b want 0", mispredict); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL balz_flush: got %b want 0", flush); end
        pred_idx = 4'd12;
        #1;
        n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL balz_bht12: got %b want 1", pred_taken); end
        @(posedge clk);
        #1;
        n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL balz_link_we_c1: got %b want 0", link_we); end
        n_cmp++; if (sel_valid !== 1'b0) begin n_err++; $display("FAIL balz_sel_valid_c1: got %b want 0", sel_valid); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] ops [3];
        logic [1:0] sts [3];
        logic [3:0] idxs [3];
        logic       preds [3];
        logic [1:0] exp_sel [3];
        logic       exp_mis [3];
        int         exp_cyc [3];
        int         k;
        int         pulses;
        ops[0] = 3'b001; sts[0] = 2'b00; idxs[0] = 4'd13; preds[0] = 1'b0; exp_sel[0] = 2'b01; exp_mis[0] = 1'b1; exp_cyc[0] = 0;
        ops[1] = 3'b010; sts[1] = 2'b00; idxs[1] = 4'd13; preds[1] = 1'b0; exp_sel[1] = 2'b00; exp_mis[1] = 1'b0; exp_cyc[1] = 3;
        ops[2] = 3'b111; sts[2] = 2'b10; idxs[2] = 4'd14; preds[2] = 1'b1; exp_sel[2] = 2'b00; exp_mis[2] = 1'b1; exp_cyc[2] = 4;
        k = 0;
        pulses = 0;
        @(negedge clk);
        res_op = ops[0]; res_status = sts[0]; res_idx = idxs[0]; res_pred_taken = preds[0]; res_valid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            if (sel_valid === 1'b1) begin
                pulses++;
                if (k < 3) begin
                    $display("txn b2b op=%b cyc=%0d -> pc_sel=%b mis=%b lwe=%b", ops[k], cyc, pc_sel, mispredict, link_we);
                    n_cmp++; if (pc_sel !== exp_sel[k]) begin n_err++; $display("FAIL b2b_pc_sel[%0d]: got %b want %b", k, pc_sel, exp_sel[k]); end
                    n_cmp++; if (mispredict !== exp_mis[k]) begin n_err++; $display("FAIL b2b_mispredict[%0d]: got %b want %b", k, mispredict, exp_mis[k]); end
                    n_cmp++; if (cyc != exp_cyc[k]) begin n_err++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", k, cyc, exp_cyc[k]); end
                    n_cmp++; if (link_we !== 1'b0) begin n_err++; $display("FAIL b2b_link_we[%0d]: got %b want 0", k, link_we); end
                    k++;
                    if (k == 3) begin
                        res_valid = 1'b0;
                    end else begin
                        res_op = ops[k]; res_status = sts[k]; res_idx = idxs[k]; res_pred_taken = preds[k];
                    end
                end
            end
        end
        res_valid = 1'b0;
        n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL b2b_pulse_count: got %0d want 3", pulses); end
        pred_idx = 4'd13;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL b2b_bht13: got %b want 0", pred_taken); end
        pred_idx = 4'd14;
        #1;
        n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL b2b_rsvd_no_write: got %b want 0", pred_taken); end
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        pred_idx       = 4'd0;
        res_valid      = 1'b0;
        res_op         = 3'b000;
        res_status     = 2'b00;
        res_idx        = 4'd0;
        res_pred_taken = 1'b0;
        test_reset();
        test_beq_mispredict();
        test_reset_mid_flush();
        test_bne_not_taken();
        test_bgez_saturate();
        test_j_balz();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
